// File: rtl/oled_init_sequencer_pkg.sv
// Shared definitions for the SSD1331 power-up/init sequencer.
//   - state encodings (value doubles as the led code)
//   - SSD1331 opcodes used outside the init table
//   - init table length and index width
// Optional feature macro: OLED_CLEAR_EN adds the CLEAR state and the
// clear-window byte lookup.
package oled_pkg;

  localparam int unsigned NUM_CMDS  = 39;
  localparam int unsigned CMD_IDX_W = $clog2(NUM_CMDS);

  localparam logic [7:0] CMD_DISPLAY_ON = 8'hAF;
  localparam logic [7:0] CMD_CLEAR      = 8'h25;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'h0,
    ST_PWR_WAIT   = 4'h1,
    ST_RES_LOW    = 4'h2,
    ST_RES_SETTLE = 4'h3,
    ST_SEND_CMDS  = 4'h4,
    ST_VCC_WAIT   = 4'h5,
    ST_SEND_ON    = 4'h6,
    ST_DONE       = 4'h7
`ifdef OLED_CLEAR_EN
    , ST_CLEAR    = 4'h8
`endif
  } state_t;

`ifdef OLED_CLEAR_EN
  localparam int unsigned NUM_CLEAR = 5;

  // Clear-window command: 25 (opcode), col start, row start, col end, row end.
  function automatic logic [7:0] clear_byte(input logic [CMD_IDX_W-1:0] i);
    case (i)
      CMD_IDX_W'(0): clear_byte = CMD_CLEAR;
      CMD_IDX_W'(1): clear_byte = 8'h00;
      CMD_IDX_W'(2): clear_byte = 8'h00;
      CMD_IDX_W'(3): clear_byte = 8'h5F;
      CMD_IDX_W'(4): clear_byte = 8'h3F;
      default:       clear_byte = 8'h00;
    endcase
  endfunction
`endif

endpackage

// File: rtl/oled_init_sequencer_if.sv
// Byte handshake between the init sequencer and the SPI master.
//   tx_data  : byte offered
//   tx_dc    : DC level for tx_data (0 = command)
//   tx_valid : tx_data/tx_dc are valid
//   tx_ready : SPI master accepts a byte this cycle
// A transfer happens on every cycle with tx_valid && tx_ready.
interface oled_init_sequencer_if;

  logic [7:0] tx_data;
  logic       tx_dc;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_dc, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_dc, input  tx_valid, output tx_ready);

endinterface

// File: rtl/oled_init_sequencer_cmd_rom.sv
// Combinational SSD1331 init command table.
//   idx        : table index, 0..NUM_CMDS-1
//   cmd_byte_c : command byte at idx (00 for indices past the table)
module oled_cmd_rom
  import oled_pkg::*;
(
  input  logic [CMD_IDX_W-1:0] idx,
  output logic [7:0]           cmd_byte_c
);

  localparam logic [7:0] INIT_CMDS [NUM_CMDS] = '{
    8'hFD, 8'h12, 8'hAE,
    8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2, 8'h00, 8'hA4,
    8'hA8, 8'h3F, 8'hAD, 8'h8E, 8'hB0, 8'h0B, 8'hB1, 8'h31, 8'hB3, 8'hF0,
    8'h8A, 8'h64, 8'h8B, 8'h78, 8'h8C, 8'h64,
    8'hBB, 8'h3A, 8'hBE, 8'h3E, 8'h87, 8'h06,
    8'h81, 8'h91, 8'h82, 8'h50, 8'h83, 8'h7D, 8'h2E
  };

  // Out-of-range reads happen on the prefetch past the last byte; never sent.
  always_comb begin
    cmd_byte_c = 8'h00;
    if (idx < CMD_IDX_W'(NUM_CMDS)) begin
      cmd_byte_c = INIT_CMDS[idx];
    end
  end

endmodule

// File: rtl/oled_init_sequencer.sv
// PmodOLEDrgb (SSD1331) power-up and init sequencer.
// Drives the PMOD_EN / RES / VCC_EN supply pins with the required waits,
// streams the init command table (DC=0) to the SPI master, then sends
// display-on and reports done.
//   CLK, rst   : clock, synchronous active-high reset
//   start      : one-cycle pulse that starts the sequence from IDLE
//   tx         : byte handshake to the SPI master (master modport)
//   PMOD_EN    : Pmod logic supply enable
//   RES        : controller reset, active low
//   VCC_EN     : panel high-voltage enable
//   busy, done : sequence running / finished
//   led        : current state code
// Optional feature macro: OLED_CLEAR_EN -- after display-on, send the
// clear-window command in a CLEAR state (led 8) before DONE.
// All outputs are registered.
module oled_init_sequencer
  import oled_pkg::*;
#(
  parameter int unsigned T_PWR_CYC = 2_000_000,
  parameter int unsigned T_RES_CYC = 300,
  parameter int unsigned T_VCC_CYC = 10_000_000
) (
  input  logic                         CLK,
  input  logic                         rst,
  input  logic                         start,
  oled_init_sequencer_if.master        tx,
  output logic                         PMOD_EN,
  output logic                         RES,
  output logic                         VCC_EN,
  output logic                         busy,
  output logic                         done,
  output logic [3:0]                   led
);

  localparam int unsigned T_MAX_A = (T_PWR_CYC > T_RES_CYC) ? T_PWR_CYC : T_RES_CYC;
  localparam int unsigned T_MAX   = (T_MAX_A > T_VCC_CYC) ? T_MAX_A : T_VCC_CYC;
  localparam int unsigned CNT_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CMD_IDX_W-1:0] idx_q, idx_d;
  logic                 pmod_en_q, pmod_en_d;
  logic                 res_q, res_d;
  logic                 vcc_en_q, vcc_en_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_dc_q, tx_dc_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [3:0]           led_q, led_d;

  logic                 xfer_c;
  logic                 wait_last_c;
  logic [CMD_IDX_W-1:0] rom_idx_c;
  logic [7:0]           rom_byte_c;

  assign xfer_c = tx_valid_q && tx.tx_ready;

  // Prefetch the byte after the current one so it can be registered on the
  // transfer edge and offered in the very next cycle.
  always_comb begin
    rom_idx_c = '0;
    if (state_q == ST_SEND_CMDS) begin
      rom_idx_c = idx_q + CMD_IDX_W'(1);
    end
  end

  oled_cmd_rom u_rom (
    .idx        (rom_idx_c),
    .cmd_byte_c (rom_byte_c)
  );

  // Last cycle of the wait belonging to the current state (counter N-1).
  always_comb begin
    wait_last_c = 1'b0;
    case (state_q)
      ST_PWR_WAIT:   wait_last_c = (cnt_q == CNT_W'(T_PWR_CYC - 1));
      ST_RES_LOW,
      ST_RES_SETTLE: wait_last_c = (cnt_q == CNT_W'(T_RES_CYC - 1));
      ST_VCC_WAIT:   wait_last_c = (cnt_q == CNT_W'(T_VCC_CYC - 1));
      default:       wait_last_c = 1'b0;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    pmod_en_d  = pmod_en_q;
    res_d      = res_q;
    vcc_en_d   = vcc_en_q;
    tx_data_d  = tx_data_q;
    tx_dc_d    = tx_dc_q;
    tx_valid_d = tx_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_PWR_WAIT;
          pmod_en_d = 1'b1;
          cnt_d     = '0;
        end
      end

      ST_PWR_WAIT: begin
        if (wait_last_c) begin
          state_d = ST_RES_LOW;
          res_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RES_LOW: begin
        if (wait_last_c) begin
          state_d = ST_RES_SETTLE;
          res_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RES_SETTLE: begin
        if (wait_last_c) begin
          // rom_idx_c is 0 here, so rom_byte_c is the first table byte.
          state_d    = ST_SEND_CMDS;
          cnt_d      = '0;
          idx_d      = '0;
          tx_data_d  = rom_byte_c;
          tx_dc_d    = 1'b0;
          tx_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SEND_CMDS: begin
        if (xfer_c) begin
          if (idx_q == CMD_IDX_W'(NUM_CMDS - 1)) begin
            state_d    = ST_VCC_WAIT;
            vcc_en_d   = 1'b1;
            tx_valid_d = 1'b0;
            cnt_d      = '0;
          end else begin
            idx_d     = idx_q + CMD_IDX_W'(1);
            tx_data_d = rom_byte_c;
          end
        end
      end

      ST_VCC_WAIT: begin
        if (wait_last_c) begin
          state_d    = ST_SEND_ON;
          cnt_d      = '0;
          tx_data_d  = CMD_DISPLAY_ON;
          tx_dc_d    = 1'b0;
          tx_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SEND_ON: begin
        if (xfer_c) begin
`ifdef OLED_CLEAR_EN
          state_d   = ST_CLEAR;
          idx_d     = '0;
          tx_data_d = clear_byte('0);
          tx_dc_d   = 1'b0;
`else
          state_d    = ST_DONE;
          tx_valid_d = 1'b0;
`endif
        end
      end

`ifdef OLED_CLEAR_EN
      ST_CLEAR: begin
        if (xfer_c) begin
          if (idx_q == CMD_IDX_W'(NUM_CLEAR - 1)) begin
            state_d    = ST_DONE;
            tx_valid_d = 1'b0;
          end else begin
            idx_d     = idx_q + CMD_IDX_W'(1);
            tx_data_d = clear_byte(idx_q + CMD_IDX_W'(1));
          end
        end
      end
`endif

      ST_DONE: begin
        state_d = ST_DONE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs follow the next state so they line up with state_q.
    busy_d = !((state_d == ST_IDLE) || (state_d == ST_DONE));
    done_d = (state_d == ST_DONE);
    led_d  = state_d;
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      pmod_en_q  <= 1'b0;
      res_q      <= 1'b1;
      vcc_en_q   <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_dc_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      led_q      <= 4'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pmod_en_q  <= pmod_en_d;
      res_q      <= res_d;
      vcc_en_q   <= vcc_en_d;
      tx_data_q  <= tx_data_d;
      tx_dc_q    <= tx_dc_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      led_q      <= led_d;
    end
  end

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_dc    = tx_dc_q;
  assign tx.tx_valid = tx_valid_q;
  assign PMOD_EN     = pmod_en_q;
  assign RES         = res_q;
  assign VCC_EN      = vcc_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign led         = led_q;

endmodule

// File: tb/tb_oled_init_sequencer.sv
// Directed bench for oled_init_sequencer. Instance A uses short waits
// (4/2/3), instance B uses all waits = 1.
module tb_oled_init_sequencer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       rst_a, start_a, pmod_a, res_a, vcc_a, busy_a, done_a;
  logic [3:0] led_a;
  logic       rst_b, start_b, pmod_b, res_b, vcc_b, busy_b, done_b;
  logic [3:0] led_b;

  oled_init_sequencer_if if_a ();
  oled_init_sequencer_if if_b ();

  oled_init_sequencer #(.T_PWR_CYC(4), .T_RES_CYC(2), .T_VCC_CYC(3)) dut_a (
    .CLK(CLK), .rst(rst_a), .start(start_a), .tx(if_a.master),
    .PMOD_EN(pmod_a), .RES(res_a), .VCC_EN(vcc_a),
    .busy(busy_a), .done(done_a), .led(led_a)
  );

  oled_init_sequencer #(.T_PWR_CYC(1), .T_RES_CYC(1), .T_VCC_CYC(1)) dut_b (
    .CLK(CLK), .rst(rst_b), .start(start_b), .tx(if_b.master),
    .PMOD_EN(pmod_b), .RES(res_b), .VCC_EN(vcc_b),
    .busy(busy_b), .done(done_b), .led(led_b)
  );

  localparam logic [7:0] ROM_EXP [39] = '{
    8'hFD, 8'h12, 8'hAE,
    8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2, 8'h00, 8'hA4,
    8'hA8, 8'h3F, 8'hAD, 8'h8E, 8'hB0, 8'h0B, 8'hB1, 8'h31, 8'hB3, 8'hF0,
    8'h8A, 8'h64, 8'h8B, 8'h78, 8'h8C, 8'h64,
    8'hBB, 8'h3A, 8'hBE, 8'h3E, 8'h87, 8'h06,
    8'h81, 8'h91, 8'h82, 8'h50, 8'h83, 8'h7D, 8'h2E
  };

`ifdef OLED_CLEAR_EN
  localparam int CLR_N = 5;
`else
  localparam int CLR_N = 0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] cap_q [$];
  logic [7:0] exp_q [$];
  logic [3:0] seq_q [$];
  logic [3:0] exp_seq [$];
  int         led_cnt [16];

  // Capture every transferred byte of instance A.
  always @(posedge CLK) begin
    if (!rst_a && if_a.tx_valid && if_a.tx_ready) cap_q.push_back(if_a.tx_data);
  end

  // A stalled offer must stay valid with unchanged data/dc on the next cycle.
  int         stable_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  logic       prev_dc    = 1'b0;
  always @(posedge CLK) begin
    if (!rst_a && prev_stall &&
        !(if_a.tx_valid && (if_a.tx_data == prev_data) && (if_a.tx_dc == prev_dc)))
      stable_err <= stable_err + 1;
    prev_stall <= !rst_a && if_a.tx_valid && !if_a.tx_ready;
    prev_data  <= if_a.tx_data;
    prev_dc    <= if_a.tx_dc;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_pmod"},  32'(pmod_a), 32'd0);
    check({tag, "_res"},   32'(res_a), 32'd1);
    check({tag, "_vcc"},   32'(vcc_a), 32'd0);
    check({tag, "_valid"}, 32'(if_a.tx_valid), 32'd0);
    check({tag, "_data"},  32'(if_a.tx_data), 32'h00);
    check({tag, "_dc"},    32'(if_a.tx_dc), 32'd0);
    check({tag, "_busy"},  32'(busy_a), 32'd0);
    check({tag, "_done"},  32'(done_a), 32'd0);
    check({tag, "_led"},   32'(led_a), 32'h0);
  endtask

  task automatic check_stream(input string tag);
    int m;
    int n;
    m = 0;
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    check({tag, "_len"}, 32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < n; i++) if (cap_q[i] !== exp_q[i]) m++;
    check({tag, "_bytes"}, 32'(m), 32'd0);
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge CLK);
    start_a = 1'b0;
  endtask

  int  n;
  int  res_low;
  bit  saw_led8;
  bit  pulsed;
  int  sz;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    if_a.tx_ready = 1'b0;
    if_b.tx_ready = 1'b1;
    foreach (ROM_EXP[i]) exp_q.push_back(ROM_EXP[i]);
    exp_q.push_back(8'hAF);
`ifdef OLED_CLEAR_EN
    exp_q.push_back(8'h25); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'h5F); exp_q.push_back(8'h3F);
`endif

    // ---- reset state ----
    repeat (2) @(negedge CLK);
    check_reset_a("rst0");
    rst_a = 1'b0;
    if_a.tx_ready = 1'b1;
    @(negedge CLK);
    check("idle_hold_led", 32'(led_a), 32'h0);
    check("idle_ready_novalid", 32'(if_a.tx_valid), 32'd0);

    // ---- run 1: ready tied high ----
    pulse_start_a();
    check("pmod_after_start", 32'(pmod_a), 32'd1);
    check("led_pwr_wait", 32'(led_a), 32'h1);
    check("busy_pwr_wait", 32'(busy_a), 32'd1);
    check("res_high_pwr", 32'(res_a), 32'd1);
    res_low = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (!res_a) res_low++;
    end
    check("res_low_cycles", 32'(res_low), 32'd2);
    check("first_valid", 32'(if_a.tx_valid), 32'd1);
    check("first_byte", 32'(if_a.tx_data), 32'hFD);
    check("first_dc", 32'(if_a.tx_dc), 32'd0);
    check("led_send_cmds", 32'(led_a), 32'h4);
    n = 0;
    while (!vcc_a && n < 200) begin @(negedge CLK); n++; end
    check("cmd_cycles", 32'(n), 32'd39);
    check("cmd_count", 32'(cap_q.size()), 32'd39);
    check("led_vcc_wait", 32'(led_a), 32'h5);
    check("valid_low_vcc", 32'(if_a.tx_valid), 32'd0);
    n = 0;
    while (!if_a.tx_valid && n < 50) begin @(negedge CLK); n++; end
    check("vcc_wait_cycles", 32'(n), 32'd3);
    check("on_byte", 32'(if_a.tx_data), 32'hAF);
    check("led_send_on", 32'(led_a), 32'h6);
    n = 0; saw_led8 = 1'b0;
    while (!done_a && n < 50) begin
      @(negedge CLK); n++;
      if (led_a == 4'h8) saw_led8 = 1'b1;
    end
    check("on_to_done", 32'(n), 32'(1 + CLR_N));
    check("led8_seen", 32'(saw_led8), 32'(CLR_N != 0));
    check("done", 32'(done_a), 32'd1);
    check("busy_done", 32'(busy_a), 32'd0);
    check("led_done", 32'(led_a), 32'h7);
    check("pmod_done", 32'(pmod_a), 32'd1);
    check("vcc_done", 32'(vcc_a), 32'd1);
    check("valid_done", 32'(if_a.tx_valid), 32'd0);
    check_stream("run1");

    // ---- run 2: random ready, start during SEND_CMDS and in DONE ----
    rst_a = 1'b1;
    @(negedge CLK);
    rst_a = 1'b0;
    cap_q.delete();
    pulse_start_a();
    n = 0; pulsed = 1'b0;
    while (!done_a && n < 3000) begin
      if_a.tx_ready = 1'($urandom_range(0, 1));
      if (!pulsed && cap_q.size() == 5) begin
        start_a = 1'b1; pulsed = 1'b1;
        @(negedge CLK); n++;
        start_a = 1'b0;
        check("start_in_cmds_led", 32'(led_a), 32'h4);
      end else begin
        @(negedge CLK); n++;
      end
    end
    check("run2_done", 32'(done_a), 32'd1);
    check_stream("run2");
    check("stall_stable", 32'(stable_err), 32'd0);
    sz = cap_q.size();
    if_a.tx_ready = 1'b1;
    pulse_start_a();
    repeat (3) @(negedge CLK);
    check("start_in_done_led", 32'(led_a), 32'h7);
    check("start_in_done_done", 32'(done_a), 32'd1);
    check("start_in_done_valid", 32'(if_a.tx_valid), 32'd0);
    check("start_in_done_bytes", 32'(cap_q.size()), 32'(sz));

    // ---- run 3: reset at byte index 10, then re-run ----
    rst_a = 1'b1;
    @(negedge CLK);
    rst_a = 1'b0;
    cap_q.delete();
    pulse_start_a();
    n = 0;
    while (cap_q.size() < 10 && n < 200) begin @(negedge CLK); n++; end
    check("idx10_byte", 32'(if_a.tx_data), 32'hA8);
    rst_a = 1'b1;
    @(negedge CLK);
    check_reset_a("rst_mid");
    rst_a = 1'b0;
    cap_q.delete();
    pulse_start_a();
    n = 0;
    while (!done_a && n < 300) begin @(negedge CLK); n++; end
    check("rerun_first", 32'(cap_q.size() > 0 ? cap_q[0] : 8'hxx), 32'hFD);
    check_stream("run3");

    // ---- instance B: all waits = 1, state trace ----
    rst_b = 1'b0;
    @(negedge CLK);
    seq_q.push_back(led_b);
    start_b = 1'b1;
    @(negedge CLK);
    start_b = 1'b0;
    n = 0;
    while (!done_b && n < 300) begin
      if (led_b != seq_q[$]) seq_q.push_back(led_b);
      led_cnt[led_b]++;
      @(negedge CLK); n++;
    end
    if (led_b != seq_q[$]) seq_q.push_back(led_b);
    for (int i = 0; i < 7; i++) exp_seq.push_back(4'(i));
`ifdef OLED_CLEAR_EN
    exp_seq.push_back(4'h8);
`endif
    exp_seq.push_back(4'h7);
    check("b_seq_len", 32'(seq_q.size()), 32'(exp_seq.size()));
    n = 0;
    for (int i = 0; i < exp_seq.size() && i < seq_q.size(); i++)
      if (seq_q[i] !== exp_seq[i]) n++;
    check("b_seq_codes", 32'(n), 32'd0);
    check("b_pwr_1cyc", 32'(led_cnt[1]), 32'd1);
    check("b_res_1cyc", 32'(led_cnt[2]), 32'd1);
    check("b_settle_1cyc", 32'(led_cnt[3]), 32'd1);
    check("b_cmds_cyc", 32'(led_cnt[4]), 32'd39);
    check("b_vcc_1cyc", 32'(led_cnt[5]), 32'd1);
    check("b_on_1cyc", 32'(led_cnt[6]), 32'd1);
    check("b_done", 32'(done_b), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/oled_init_sequencer.md
Name: oled_init_sequencer

Overview:
- Upstream stage of the SPI master on the PmodOLEDrgb (SSD1331) path.
- Runs the display power-up sequence on the PMOD_EN, RES and VCC_EN pins.
- Streams the controller's init command bytes, with DC=0, to the SPI master over a valid/ready byte handshake.
- Signals done once the display is on; the pixel-data stage takes over the SPI master after that.

Parameters:
- T_PWR_CYC, 2_000_000: CLK cycles from PMOD_EN high to the reset pulse (20 ms at 100 MHz).
- T_RES_CYC, 300: CLK cycles RES is held low, and also the settle time after RES returns high.
- T_VCC_CYC, 10_000_000: CLK cycles from VCC_EN high to the display-on command (100 ms).
- NUM_CMDS, 39: number of bytes in the init command ROM.

Ports:
- CLK, input, 1: system clock.
- rst, input, 1: reset. One clock; reset is synchronous and active-high.
- start, input, 1: single-cycle pulse that begins the sequence (debounced upstream).
- tx_data, output, 8: byte offered to the SPI master.
- tx_dc, output, 1: DC value for tx_data; 0 = command.
- tx_valid, output, 1: tx_data/tx_dc are valid.
- tx_ready, input, 1: SPI master can accept a byte.
- PMOD_EN, output, 1: Pmod logic supply enable.
- RES, output, 1: controller reset, active low.
- VCC_EN, output, 1: panel high-voltage enable.
- busy, output, 1: high in every state except IDLE and DONE.
- done, output, 1: high in DONE.
- led, output, 4: current state code.

Behaviour:
- Reset (synchronous, takes priority in every state) drives:
  - state=IDLE;
  - PMOD_EN=0, RES=1, VCC_EN=0;
  - tx_valid=0, tx_data=8'h00, tx_dc=0;
  - busy=0, done=0, led=4'h0;
  - wait counter and ROM index = 0.
- Reset mid-sequence drops tx_valid the following cycle. Upstream guarantees the SPI master is reset on the same rst.
- All outputs are registered.
- States, with their led codes:
  - IDLE (0): start=1 → PWR_WAIT, set PMOD_EN=1, clear counter. start is ignored in all other states.
  - PWR_WAIT (1): count T_PWR_CYC cycles → RES_LOW, RES=0.
  - RES_LOW (2): count T_RES_CYC cycles → RES_SETTLE, RES=1.
  - RES_SETTLE (3): count T_RES_CYC cycles → SEND_CMDS, index=0.
  - SEND_CMDS (4): present ROM[index], tx_dc=0, tx_valid=1.
    - Transfer on a cycle with tx_valid&&tx_ready; then index+1.
    - Transfer with index=NUM_CMDS-1 → VCC_WAIT, VCC_EN=1, tx_valid=0.
  - VCC_WAIT (5): count T_VCC_CYC cycles → SEND_ON.
  - SEND_ON (6): present 8'hAF with tx_valid=1; on transfer → DONE.
  - DONE (7): done=1, busy=0. Terminal until rst; PMOD_EN and VCC_EN stay 1.
- Wait timing: a wait of N cycles means exactly N CLK edges in the wait state (counter 0..N-1, exit when it equals N-1). N=1 is legal.
- Handshake:
  - Once tx_valid rises, tx_data and tx_dc are held stable until the transfer cycle.
  - At most one transfer per cycle.
  - After a transfer, the next byte is presented in the immediately following cycle. tx_valid stays high between consecutive SEND_CMDS bytes, so back-to-back transfers are possible.
  - tx_ready stalls of any length are tolerated with no byte lost or duplicated.
  - tx_ready high while tx_valid=0 has no effect.
- ROM contents, in order:
  - FD 12 AE
  - A0 72 A1 00 A2 00 A4
  - A8 3F AD 8E B0 0B B1 31 B3 F0
  - 8A 64 8B 78 8C 64
  - BB 3A BE 3E 87 06
  - 81 91 82 50 83 7D 2E
- Counter width: $clog2 of the largest T_*_CYC, minimum 1. Index width: $clog2(NUM_CMDS).

Optional Feature:
- Macro OLED_CLEAR_EN.
- When defined: after the 8'hAF transfer, enter CLEAR (led 8) and send the clear-window command 25 00 00 5F 3F (tx_dc=0) with the same handshake; after the last byte, go to DONE.
- When undefined: SEND_ON goes straight to DONE, and no CLEAR state or logic exists.

Decomposition:
- Shared package oled_pkg holds:
  - state encodings/led codes;
  - SSD1331 opcode constants (CMD_DISPLAY_ON=8'hAF, CMD_CLEAR=8'h25);
  - NUM_CMDS.
- One sub-module, oled_cmd_rom: combinational index→byte lookup of the init table. The sequencer instantiates it.

Test Plan:
- T_PWR=4, T_RES=2, T_VCC=3, tx_ready tied 1, start pulse:
  - PMOD_EN rises the cycle after start;
  - RES low for exactly 2 cycles;
  - 39 bytes FD..2E transfer on consecutive cycles, then VCC_EN=1;
  - after 3 cycles, AF transfers, then done=1.
- tx_ready toggled pseudo-randomly (~50% duty): the captured byte stream equals the ROM plus AF exactly. tx_data never changes while tx_valid=1 and tx_ready=0.
- start pulsed again during SEND_CMDS and in DONE: no restart, no extra bytes, state unchanged.
- rst asserted at byte index 10, then released and start pulsed: all outputs return to reset values on the next edge; the re-run sequence begins again from FD.
- All T_*_CYC=1: each wait lasts 1 cycle, and the state sequence and led codes are 0,1,2,3,4,5,6,7.
- OLED_CLEAR_EN defined: after AF, bytes 25 00 00 5F 3F are sent before done=1; led=8 during the clear.
